// File: rtl/mano_ctrl_seq.sv
// Mano basic computer control sequencer: owns the timing counter and run flag,
// decodes IR and issues per-cycle register, memory and bus controls.
module mano_ctrl_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] IN_IR,
  input  logic        DR_ZERO,
  output logic [2:0]  t,
  output logic [7:0]  D,
  output logic        I,
  output logic        S,
  output logic [2:0]  BUS_SEL,
  output logic        LD_AR,
  output logic        LD_IR,
  output logic        LD_PC,
  output logic        LD_DR,
  output logic        INR_PC,
  output logic        INR_AR,
  output logic        INR_DR,
  output logic        MEM_WR,
  output logic        ALU_EN,
  output logic        EXEC_RR,
  output logic        EXEC_IO
);

  typedef enum logic [2:0] {
    T0, T1, T2, T3, T4, T5, T6, T7
  } tstate_e;

  typedef enum logic [2:0] {
    BUS_NONE, BUS_AR, BUS_PC, BUS_DR,
    BUS_AC, BUS_IR, BUS_TR, BUS_MEM
  } bus_e;

  tstate_e    t_q, t_d;
  logic [7:0] d_q, d_d;
  logic       i_q, i_d;
  logic       s_q, s_d;

  bus_e bus;
  logic clr;
  logic ld_ar, ld_ir, ld_pc, ld_dr;
  logic inr_pc, inr_ar, inr_dr;
  logic mem_wr, alu_en, exec_rr, exec_io;

  // Address field and remaining RR/IO bits are consumed by the datapath.
  logic unused_ir;
  assign unused_ir = ^IN_IR[11:1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      t_q <= T0;
      d_q <= '0;
      i_q <= 1'b0;
      s_q <= 1'b1;
    end else begin
      t_q <= t_d;
      d_q <= d_d;
      i_q <= i_d;
      s_q <= s_d;
    end
  end

  always_comb begin
    t_d     = t_q;
    d_d     = d_q;
    i_d     = i_q;
    s_d     = s_q;
    clr     = 1'b0;
    bus     = BUS_NONE;
    ld_ar   = 1'b0;
    ld_ir   = 1'b0;
    ld_pc   = 1'b0;
    ld_dr   = 1'b0;
    inr_pc  = 1'b0;
    inr_ar  = 1'b0;
    inr_dr  = 1'b0;
    mem_wr  = 1'b0;
    alu_en  = 1'b0;
    exec_rr = 1'b0;
    exec_io = 1'b0;

    if (s_q && !RST) begin
      t_d = tstate_e'(t_q + 3'd1);
      unique case (t_q)
        T0: begin
          bus   = BUS_PC;
          ld_ar = 1'b1;
        end
        T1: begin
          bus    = BUS_MEM;
          ld_ir  = 1'b1;
          inr_pc = 1'b1;
        end
        T2: begin
          d_d   = 8'd1 << IN_IR[14:12];
          i_d   = IN_IR[15];
          bus   = BUS_IR;
          ld_ar = 1'b1;
        end
        T3: begin
          if (d_q[7]) begin
            clr = 1'b1;
            if (i_q) begin
              exec_io = 1'b1;
            end else begin
              exec_rr = 1'b1;
              if (IN_IR[0]) s_d = 1'b0;
            end
          end else if (i_q) begin
            bus   = BUS_MEM;
            ld_ar = 1'b1;
          end
        end
        T4: begin
          unique case (1'b1)
            d_q[0], d_q[1], d_q[2], d_q[6]: begin
              bus   = BUS_MEM;
              ld_dr = 1'b1;
            end
            d_q[3]: begin
              bus    = BUS_AC;
              mem_wr = 1'b1;
              clr    = 1'b1;
            end
            d_q[4]: begin
              bus   = BUS_AR;
              ld_pc = 1'b1;
              clr   = 1'b1;
            end
            d_q[5]: begin
              bus    = BUS_PC;
              mem_wr = 1'b1;
              inr_ar = 1'b1;
            end
            default: clr = 1'b1;
          endcase
        end
        T5: begin
          unique case (1'b1)
            d_q[0], d_q[1], d_q[2]: begin
              alu_en = 1'b1;
              clr    = 1'b1;
            end
            d_q[5]: begin
              bus   = BUS_AR;
              ld_pc = 1'b1;
              clr   = 1'b1;
            end
            d_q[6]: inr_dr = 1'b1;
            default: clr = 1'b1;
          endcase
        end
        T6: begin
          clr = 1'b1;
          if (d_q[6]) begin
            bus    = BUS_DR;
            mem_wr = 1'b1;
            inr_pc = DR_ZERO;
          end
        end
        T7: clr = 1'b1;
        default: clr = 1'b1;
      endcase
      if (clr) t_d = T0;
    end
  end

  assign t       = t_q;
  assign D       = d_q;
  assign I       = i_q;
  assign S       = s_q;
  assign BUS_SEL = bus;
  assign LD_AR   = ld_ar;
  assign LD_IR   = ld_ir;
  assign LD_PC   = ld_pc;
  assign LD_DR   = ld_dr;
  assign INR_PC  = inr_pc;
  assign INR_AR  = inr_ar;
  assign INR_DR  = inr_dr;
  assign MEM_WR  = mem_wr;
  assign ALU_EN  = alu_en;
  assign EXEC_RR = exec_rr;
  assign EXEC_IO = exec_io;

endmodule

// File: tb/tb_mano_ctrl_seq.sv
// Bench for mano_ctrl_seq: directed and random instructions checked
// against an instruction-level table of expected per-cycle controls.
module tb_mano_ctrl_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] IN_IR;
  logic        DR_ZERO;
  logic [2:0]  t;
  logic [7:0]  D;
  logic        I, S;
  logic [2:0]  BUS_SEL;
  logic        LD_AR, LD_IR, LD_PC, LD_DR;
  logic        INR_PC, INR_AR, INR_DR;
  logic        MEM_WR, ALU_EN, EXEC_RR, EXEC_IO;

  mano_ctrl_seq dut (
    .CLK(CLK), .RST(RST), .IN_IR(IN_IR), .DR_ZERO(DR_ZERO),
    .t(t), .D(D), .I(I), .S(S), .BUS_SEL(BUS_SEL),
    .LD_AR(LD_AR), .LD_IR(LD_IR), .LD_PC(LD_PC), .LD_DR(LD_DR),
    .INR_PC(INR_PC), .INR_AR(INR_AR), .INR_DR(INR_DR),
    .MEM_WR(MEM_WR), .ALU_EN(ALU_EN),
    .EXEC_RR(EXEC_RR), .EXEC_IO(EXEC_IO)
  );

  always #5 CLK = ~CLK;

  localparam logic [10:0] M_LDAR = 11'h400;
  localparam logic [10:0] M_LDIR = 11'h200;
  localparam logic [10:0] M_LDPC = 11'h100;
  localparam logic [10:0] M_LDDR = 11'h080;
  localparam logic [10:0] M_INPC = 11'h040;
  localparam logic [10:0] M_INAR = 11'h020;
  localparam logic [10:0] M_INDR = 11'h010;
  localparam logic [10:0] M_MWR  = 11'h008;
  localparam logic [10:0] M_ALU  = 11'h004;
  localparam logic [10:0] M_XRR  = 11'h002;
  localparam logic [10:0] M_XIO  = 11'h001;

  logic [13:0] got_sv;
  assign got_sv = {BUS_SEL, LD_AR, LD_IR, LD_PC, LD_DR, INR_PC,
                   INR_AR, INR_DR, MEM_WR, ALU_EN, EXEC_RR, EXEC_IO};

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] prev_d;
  logic       prev_i;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] sv(input logic [2:0] b,
                                     input logic [10:0] m);
    return {b, m};
  endfunction

  task automatic run_instr(input logic [15:0] ir, input logic dz,
                           input int abort_k, output bit halted);
    logic [13:0] exp_q[$];
    logic [2:0]  op;
    logic        ind;
    logic [7:0]  one, new_d;
    op     = ir[14:12];
    ind    = ir[15];
    one    = 8'd1;
    new_d  = one << op;
    halted = 1'b0;
    exp_q.push_back(sv(3'd2, M_LDAR));
    exp_q.push_back(sv(3'd7, M_LDIR | M_INPC));
    exp_q.push_back(sv(3'd5, M_LDAR));
    if (op == 3'd7) begin
      exp_q.push_back(sv(3'd0, ind ? M_XIO : M_XRR));
      halted = !ind && ir[0];
    end else begin
      exp_q.push_back(ind ? sv(3'd7, M_LDAR) : sv(3'd0, 11'h0));
      case (op)
        3'd0, 3'd1, 3'd2: begin
          exp_q.push_back(sv(3'd7, M_LDDR));
          exp_q.push_back(sv(3'd0, M_ALU));
        end
        3'd3: exp_q.push_back(sv(3'd4, M_MWR));
        3'd4: exp_q.push_back(sv(3'd1, M_LDPC));
        3'd5: begin
          exp_q.push_back(sv(3'd2, M_MWR | M_INAR));
          exp_q.push_back(sv(3'd1, M_LDPC));
        end
        default: begin
          exp_q.push_back(sv(3'd7, M_LDDR));
          exp_q.push_back(sv(3'd0, M_INDR));
          exp_q.push_back(sv(3'd3, M_MWR | (dz ? M_INPC : 11'h0)));
        end
      endcase
    end
    IN_IR   = ir;
    DR_ZERO = dz;
    for (int k = 0; k < exp_q.size(); k++) begin
      #1;
      check($sformatf("ir%h t%0d t", ir, k), 32'(t), k);
      check($sformatf("ir%h t%0d S", ir, k), 32'(S), 1);
      check($sformatf("ir%h t%0d ctl", ir, k), 32'(got_sv),
            32'(exp_q[k]));
      check($sformatf("ir%h t%0d D", ir, k), 32'(D),
            (k < 3) ? 32'(prev_d) : 32'(new_d));
      check($sformatf("ir%h t%0d I", ir, k), 32'(I),
            (k < 3) ? 32'(prev_i) : 32'(ind));
      if (k == abort_k) begin
        RST = 1'b1;
        @(negedge CLK);
        #1;
        check("abort t", 32'(t), 0);
        check("abort D", 32'(D), 0);
        check("abort S", 32'(S), 1);
        check("abort ctl", 32'(got_sv), 0);
        RST    = 1'b0;
        prev_d = '0;
        prev_i = 1'b0;
        halted = 1'b0;
        return;
      end
      @(negedge CLK);
    end
    prev_d = new_d;
    prev_i = ind;
  endtask

  task automatic halt_tail();
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("halt%0d t", k), 32'(t), 0);
      check($sformatf("halt%0d S", k), 32'(S), 0);
      check($sformatf("halt%0d ctl", k), 32'(got_sv), 0);
      @(negedge CLK);
    end
    RST = 1'b1;
    @(negedge CLK);
    #1;
    check("restart S", 32'(S), 1);
    check("restart t", 32'(t), 0);
    check("restart ctl", 32'(got_sv), 0);
    RST    = 1'b0;
    prev_d = '0;
    prev_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    logic [15:0] ir;
    RST     = 1'b1;
    IN_IR   = '0;
    DR_ZERO = 1'b0;
    prev_d  = '0;
    prev_i  = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    check("rst t", 32'(t), 0);
    check("rst S", 32'(S), 1);
    check("rst D", 32'(D), 0);
    check("rst I", 32'(I), 0);
    check("rst ctl", 32'(got_sv), 0);
    RST = 1'b0;

    run_instr(16'h5123, 1'b0, -1, h);
    run_instr(16'h8000, 1'b0, -1, h);
    run_instr(16'h6010, 1'b1, -1, h);
    run_instr(16'h6010, 1'b0, -1, h);
    run_instr(16'hF800, 1'b0, -1, h);
    run_instr(16'h6010, 1'b1, 5, h);
    run_instr(16'h7001, 1'b0, -1, h);
    check("hlt flag", 32'(h), 1);
    if (h) halt_tail();

    for (int n = 0; n < 80; n++) begin
      ir = 16'($urandom);
      run_instr(ir, 1'($urandom), -1, h);
      if (h) halt_tail();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mano_ctrl_seq.md
Name: mano_ctrl_seq

Overview:
- Control sequencer for the Mano basic computer: the consumer of the instruction register.
- Owns the sequence counter (timing t) and the start/stop flip-flop S.
- Reads IR contents, latches the decoded opcode D[7:0] and the indirect bit I.
- Emits per-cycle register/memory control strobes and common-bus select for fetch, decode, indirect and memory-reference execution; hands register-reference and I/O execution to the datapath via one-cycle strobes.

Parameters:
- None. Fixed 16-bit IR, 3-bit sequence counter; max t = 6.

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- IN_IR  in  16  current IR register output; valid from t=2 of every instruction
- DR_ZERO  in  1  DR == 0 after increment; sampled only at ISZ t=6
- t  out  3  sequence counter value (T0..T6)
- D  out  8  one-hot opcode decode of IR[14:12], latched at t=2
- I  out  1  IR[15], latched at t=2
- S  out  1  run flag; 1 = running
- BUS_SEL  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
- LD_AR, LD_IR, LD_PC, LD_DR  out  1  register load strobes
- INR_PC, INR_AR, INR_DR  out  1  increment strobes
- MEM_WR  out  1  memory write strobe
- ALU_EN  out  1  AC <- ALU(op per D) strobe
- EXEC_RR  out  1  register-reference execute strobe
- EXEC_IO  out  1  I/O execute strobe

Behaviour:
- Reset value of every output:
  - t = 0, D = 0, I = 0, S = 1.
  - All strobes = 0; BUS_SEL = 0.
- RST overrides everything, including mid-instruction.
- All strobes are combinational from (t, D, I, S). Strobes and BUS_SEL are 0 whenever S = 0.
- Sequence counter:
  - Increments each cycle while S = 1.
  - Any "clear" cycle below loads t = 0 on the next edge.
  - When S = 0, t holds.
- t=0 (fetch):
  - BUS_SEL=2, LD_AR.
- t=1 (fetch):
  - BUS_SEL=7, LD_IR, INR_PC.
- t=2 (decode):
  - D <= onehot(IN_IR[14:12]), I <= IN_IR[15].
  - BUS_SEL=5, LD_AR (AR <= IR[11:0]).
- t=3 with D[7]=1, I=0 (register-reference):
  - EXEC_RR=1, clear.
  - If IN_IR[0]=1 (HLT), S <= 0 on the same edge.
  - If both IN_IR[0] and RST are high, RST wins.
- t=3 with D[7]=1, I=1 (I/O):
  - EXEC_IO=1, clear.
- t=3 with D[7]=0:
  - If I=1, indirect: BUS_SEL=7, LD_AR.
  - If I=0, no strobes.
  - In both cases proceed to t=4.
- t>=4 (memory-reference execution):
  - AND/ADD/LDA (D0/D1/D2):
    - t4: BUS_SEL=7, LD_DR.
    - t5: ALU_EN, clear.
  - STA (D3):
    - t4: BUS_SEL=4, MEM_WR, clear.
  - BUN (D4):
    - t4: BUS_SEL=1, LD_PC, clear.
  - BSA (D5):
    - t4: BUS_SEL=2, MEM_WR, INR_AR.
    - t5: BUS_SEL=1, LD_PC, clear.
  - ISZ (D6):
    - t4: BUS_SEL=7, LD_DR.
    - t5: INR_DR.
    - t6: BUS_SEL=3, MEM_WR, INR_PC if DR_ZERO; clear.
- Instruction lengths in cycles:
  - Register-ref / I/O: 4.
  - STA, BUN: 5 (+0 for indirect; the t3 slot is always consumed).
  - AND/ADD/LDA, BSA: 6.
  - ISZ: 7.
- D and I hold from t=2 through the instruction's clear cycle; they change only at the next t=2.
- Illegal state t=7 (unreachable): force clear, no strobes.
- Once halted, only RST restarts. After RST, S=1 and fetch begins at t=0 on the following cycle.

Test Plan:
- RST=1 for 2 cycles, then release -> t=0, S=1, all strobes 0 during reset. After release t counts 0,1,2; LD_AR at t0, LD_IR+INR_PC at t1.
- IN_IR=16'h5123 (BSA, direct):
  - t2 -> D=8'h20, I=0.
  - t4: BUS_SEL=2, MEM_WR, INR_AR.
  - t5: BUS_SEL=1, LD_PC.
  - Next cycle t=0.
- IN_IR=16'h8000 (AND, indirect):
  - t3: BUS_SEL=7, LD_AR.
  - t4: LD_DR.
  - t5: ALU_EN, then t=0 (6 cycles total).
- IN_IR=16'h6010 (ISZ):
  - With DR_ZERO=1 -> t6 asserts MEM_WR, BUS_SEL=3, INR_PC.
  - Repeat with DR_ZERO=0 -> INR_PC=0 at t6.
- IN_IR=16'h7001 (HLT):
  - t3: EXEC_RR=1, then S=0.
  - t holds at 0 for 10 cycles, all strobes 0.
  - RST restores S=1 and fetch resumes.
- IN_IR=16'hF800 (I/O):
  - t3: EXEC_IO=1, then t=0.
  - Assert RST at t=5 of an ISZ -> next cycle t=0, D=0, no MEM_WR issued.
